// File: rtl/par3_ser.sv
// Serialises 3-sample words (y0, y1, y2) from a 2-deep FIFO onto a single 19-bit stream.
// Optional macro PAR3_SER_SAT_EN clamps every stored sample to 16'hFFFF.
module par3_ser (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [18:0] in_y0,
  input  logic [18:0] in_y1,
  input  logic [18:0] in_y2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [18:0] dout,
  output logic        out_last
);

  typedef enum logic [1:0] {StP0, StP1, StP2} phase_e;

  phase_e            phase_q, phase_d;
  logic [2:0][18:0]  word_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;
  logic              push, pop, retire;
  logic [2:0][18:0]  head;

  function automatic logic [18:0] sat(input logic [18:0] x);
`ifdef PAR3_SER_SAT_EN
    sat = (x > 19'h0FFFF) ? 19'h0FFFF : x;
`else
    sat = x;
`endif
  endfunction

  always_comb begin
    out_valid = (count_q != 2'd0);
    pop       = out_valid && out_ready;
    retire    = pop && (phase_q == StP2);
    // A full FIFO can still take a word when its head retires this cycle.
    in_ready  = !rst && ((count_q != 2'd2) || retire);
    push      = in_valid && in_ready;
    count_d   = count_q + {1'b0, push} - {1'b0, retire};

    phase_d = phase_q;
    if (pop) begin
      case (phase_q)
        StP0:    phase_d = StP1;
        StP1:    phase_d = StP2;
        default: phase_d = StP0;
      endcase
    end

    head     = word_q[rd_ptr_q];
    dout     = '0;
    out_last = 1'b0;
    if (out_valid) begin
      case (phase_q)
        StP0:    dout = head[0];
        StP1:    dout = head[1];
        StP2:    dout = head[2];
        default: dout = '0;
      endcase
      out_last = (phase_q == StP2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= StP0;
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      word_q[0] <= '0;
      word_q[1] <= '0;
    end else begin
      phase_q <= phase_d;
      count_q <= count_d;
      if (push) begin
        word_q[wr_ptr_q] <= {sat(in_y2), sat(in_y1), sat(in_y0)};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (retire) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: doc/par3_ser.md
PAR3_SER -- requirements
Module: par3_ser

Interface
REQ-001: The block SHALL have no parameters; data width is fixed at 19 bits (the 3-parallel filter output width) and buffer depth is fixed at 2 words.
REQ-002: clk  input  1  single clock; all state updates on the rising edge.
REQ-003: rst  input  1  reset, asynchronous and active-high.
REQ-004: in_valid  input  1  producer has a 3-sample word on in_y0/in_y1/in_y2.
REQ-005: in_ready  output  1  block can accept a word this cycle.
REQ-006: in_y0  input  19  sample y(3k), earliest in time.
REQ-007: in_y1  input  19  sample y(3k+1).
REQ-008: in_y2  input  19  sample y(3k+2), latest in time.
REQ-009: out_valid  output  1  dout carries a valid serial sample.
REQ-010: out_ready  input  1  consumer takes dout this cycle.
REQ-011: dout  output  19  serial sample stream.
REQ-012: out_last  output  1  dout is the third sample (y(3k+2)) of its word.

Function
REQ-013: The block SHALL accept a word on every rising edge where in_valid and in_ready are both 1, and SHALL ignore input data in all other cycles.
REQ-014: The block SHALL hold accepted words in a 2-entry FIFO, with a word count of 0, 1 or 2.
REQ-015: in_ready SHALL be 1 when count < 2, or when count == 2 and the last sample of the head word pops in the same cycle; otherwise in_ready SHALL be 0.
REQ-016: out_valid SHALL be 1 exactly when count > 0.
REQ-017: Serialisation state: a phase counter with states P0, P1, P2.
REQ-018: In each phase, dout SHALL present the head word's sample for that phase: P0 → y0, P1 → y1, P2 → y2.
REQ-019: dout SHALL be driven from registered storage only, with no combinational path from in_y* to dout.
REQ-020: A pop occurs when out_valid and out_ready are both 1; on a pop the phase advances P0 → P1 → P2 → P0.
REQ-021: The P2 → P0 transition SHALL retire the head word.
REQ-022: When out_ready is 0, phase, dout and out_last SHALL hold their values.
REQ-023: out_last SHALL be 1 only when out_valid is 1 and phase == P2.
REQ-024: Latency: a word accepted at rising edge N into an empty FIFO SHALL appear as y0 on dout, with out_valid = 1, in the cycle following edge N.
REQ-025: Throughput: one sample per clock while out_ready is 1; with a constant out_ready, back-to-back words SHALL stream with no bubble between the y2 of one word and the y0 of the next.
REQ-026: Simultaneous accept and head-word retire in the same cycle SHALL leave count unchanged.
REQ-027: Words SHALL be emitted in acceptance order.
REQ-028: When out_valid is 0, dout SHALL be 0.
REQ-029: No overflow is possible, because in_ready back-pressures; no underflow is possible, because out_valid gates pops.

Reset
REQ-030: While rst is 1, the following SHALL hold, asynchronously and immediately: count = 0, phase = P0, storage cleared to 0, out_valid = 0, out_last = 0, dout = 0, in_ready = 0.
REQ-031: Reset asserted mid-word SHALL discard all buffered and partially emitted samples; there is no resumption.
REQ-032: On the first rising edge after rst deasserts, the block SHALL have in_ready = 1 and be able to accept a word.

Configuration
REQ-033: With the macro PAR3_SER_SAT_EN defined, every sample SHALL be clamped at 16'hFFFF before it is stored: stored value = min(sample, 65535), zero-extended to 19 bits.
REQ-034: Without PAR3_SER_SAT_EN, samples SHALL pass through unmodified at the full 19 bits.
REQ-035: Handshake behaviour and timing SHALL be identical with and without PAR3_SER_SAT_EN.

Verification
REQ-036: Basic order: after reset, word (1,2,3), out_ready = 1 → dout = 1,2,3 on three consecutive cycles starting one cycle after accept; out_last = 1 only with dout = 3; then out_valid = 0 and dout = 0.
REQ-037: Back-pressure: in_valid held 1 with words (10,11,12), (20,21,22), (30,31,32) and out_ready = 1 → continuous stream 10..32; in_ready = 0 whenever count = 2 with no pop of a y2 that cycle; no sample lost or duplicated.
REQ-038: Output stall: word (5,6,7), out_ready = 0 for 4 cycles after the first output → dout holds 5 with out_valid = 1; on release → 6 then 7 with no gap.
REQ-039: Reset mid-operation: after word (100,200,300) has emitted 100, assert rst for 1 cycle → out_valid = 0 and dout = 0 immediately; after release, word (1,1,1) → only 1,1,1 emitted.
REQ-040: Saturation: word (19'h7FFFF, 19'h0FFFF, 19'h10000) → with PAR3_SER_SAT_EN: 19'h0FFFF, 19'h0FFFF, 19'h0FFFF; without: 19'h7FFFF, 19'h0FFFF, 19'h10000.
